// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - receive-side slot demultiplexer for a counter-driven N:1 serial TDM link
//
// Ports:
//   clk       rising-edge clock
//   rstn      asynchronous active-low reset
//   in        serial slot bit, sampled when en=1
//   en        slot strobe; in/sync are ignored while en=0
//   sync      frame marker, expected with en on slot 0 of every frame
//   out       last completed frame, out[k] = bit received in slot k
//   valid     one-cycle pulse, out was just updated
//   locked    high while frame alignment is held
//   frame_err one-cycle pulse, missing or early sync marker
//   slot      index of the next expected slot
module tdm_demux #(
    parameter int N  = 8,
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in,
    input  logic          en,
    input  logic          sync,
    output logic [N-1:0]  out,
    output logic          valid,
    output logic          locked,
    output logic          frame_err,
    output logic [SW-1:0] slot
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [SW-1:0] LAST_SLOT = SW'(N - 1);

    state_t        state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [N-1:0]  shadow_q, shadow_d;
    logic [N-1:0]  out_q, out_d;
    logic          valid_d;
    logic          err_d;
    logic          locked_q;
    logic          valid_q;
    logic          err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= HUNT;
            slot_q   <= '0;
            shadow_q <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            locked_q <= (state_d == LOCKED);
        end
    end

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        shadow_d = shadow_q;
        out_d    = out_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        if (en) begin
            case (state_q)
                HUNT: begin
                    if (sync) begin
                        shadow_d[0] = in;
                        slot_d      = SW'(1);
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sync) begin
                        // A marker anywhere but slot 0 aborts the partial frame,
                        // but we trust it and realign rather than dropping lock.
                        err_d       = (slot_q != '0);
                        shadow_d[0] = in;
                        slot_d      = SW'(1);
                    end else if (slot_q == '0) begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                        slot_d  = '0;
                    end else begin
                        shadow_d[slot_q] = in;
                        slot_d           = slot_q + SW'(1);
                        if (slot_q == LAST_SLOT) begin
                            // Bypass the shadow for the final bit so out updates
                            // on the same edge that samples slot N-1.
                            out_d   = {in, shadow_q[N-2:0]};
                            valid_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = '0;
                end
            endcase
        end
    end

    assign out       = out_q;
    assign valid     = valid_q;
    assign frame_err = err_q;
    assign locked    = locked_q;
    assign slot      = slot_q;

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - self-checking bench for tdm_demux against a frame-level reference model
module tb_tdm_demux;

    localparam int N  = 8;
    localparam int SW = 3;

    logic          clk;
    logic          rstn;
    logic          s_in;
    logic          s_en;
    logic          s_sync;
    logic [N-1:0]  d_out;
    logic          d_valid;
    logic          d_locked;
    logic          d_err;
    logic [SW-1:0] d_slot;

    int checks = 0;
    int errors = 0;

    // reference model state: frame position as a plain integer, word built arithmetically
    bit     m_locked;
    int     m_pos;
    longint m_word;
    longint m_out;
    bit     m_valid;
    bit     m_err;

    tdm_demux #(.N(N), .SW(SW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in        (s_in),
        .en        (s_en),
        .sync      (s_sync),
        .out       (d_out),
        .valid     (d_valid),
        .locked    (d_locked),
        .frame_err (d_err),
        .slot      (d_slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_pos    = 0;
        m_word   = 0;
        m_out    = 0;
        m_valid  = 0;
        m_err    = 0;
    endtask

    task automatic model_step(input bit e, input bit sy, input bit b);
        m_valid = 0;
        m_err   = 0;
        if (!e) return;
        if (!m_locked) begin
            if (sy) begin
                m_locked = 1;
                m_word   = longint'(b);
                m_pos    = 1;
            end
        end else if (sy) begin
            m_err  = (m_pos != 0);
            m_word = longint'(b);
            m_pos  = 1;
        end else if (m_pos == 0) begin
            m_err    = 1;
            m_locked = 0;
        end else begin
            m_word = m_word + (longint'(b) << m_pos);
            m_pos  = m_pos + 1;
            if (m_pos == N) begin
                m_out   = m_word;
                m_valid = 1;
                m_pos   = 0;
            end
        end
    endtask

    task automatic check_all();
        check("valid", d_valid, m_valid);
        check("frame_err", d_err, m_err);
        check("locked", d_locked, m_locked);
        check("slot", d_slot, m_pos);
        check("out", d_out, m_out);
    endtask

    // one clock: drive, clock, advance model, sample 1 time unit after the edge
    task automatic cyc(input bit e, input bit sy, input bit b);
        s_en   = e;
        s_sync = sy;
        s_in   = b;
        @(posedge clk);
        model_step(e, sy, b);
        #1;
        check_all();
    endtask

    task automatic send_frame(input logic [N-1:0] v, input bit gaps);
        for (int k = 0; k < N; k++) begin
            cyc(1'b1, k == 0, v[k]);
            if (gaps) cyc(1'b0, 1'b0, 1'($urandom));
        end
    endtask

    initial begin
        logic [N-1:0] w;
        bit e, sy;
        rstn   = 1'b0;
        s_in   = 1'b0;
        s_en   = 1'b0;
        s_sync = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rstn = 1'b1;

        // three back-to-back frames, continuous en
        send_frame(8'hA5, 0);
        check("plan_a5", d_out, 8'hA5);
        send_frame(8'h3C, 0);
        check("plan_3c", d_out, 8'h3C);
        send_frame(8'hFF, 0);
        check("plan_ff", d_out, 8'hFF);

        // missing marker after a good frame, then relock
        cyc(1'b1, 1'b0, 1'b1);
        check("miss_err", d_err, 1'b1);
        check("miss_unlock", d_locked, 1'b0);
        check("miss_hold", d_out, 8'hFF);
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 1'($urandom));
        send_frame(8'h81, 0);
        check("hunt_81", d_out, 8'h81);

        // en toggling every cycle
        send_frame(8'h5A, 1);
        check("gap_5a", d_out, 8'h5A);

        // early marker at slot 4, then a full frame from it
        w = 8'h66;
        for (int k = 0; k < 4; k++) cyc(1'b1, k == 0, w[k]);
        send_frame(8'hC3, 0);
        check("early_c3", d_out, 8'hC3);
        check("early_locked", d_locked, 1'b1);

        // asynchronous reset mid-frame at slot 5
        w = 8'h99;
        for (int k = 0; k < 5; k++) cyc(1'b1, k == 0, w[k]);
        #3 rstn = 1'b0;
        #1;
        model_reset();
        check_all();
        check("rst_out", d_out, 0);
        #2 rstn = 1'b1;
        for (int k = 5; k < N; k++) cyc(1'b1, 1'b0, w[k]);
        send_frame(8'h17, 0);
        check("rst_17", d_out, 8'h17);

        // randomized traffic with gaps, occasional missing and early markers
        for (int i = 0; i < 600; i++) begin
            e = ($urandom % 10) < 7;
            if (m_pos == 0) sy = ($urandom % 12) != 0;
            else            sy = ($urandom % 25) == 0;
            cyc(e, sy, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
